fft_mem_sequencer: RTL and testbench

//  Parametrised, runtime-sized successor to the fixed 64-point FFT memory controller.

---
 rtl/fft_mem_sequencer_if.sv | 43 ++++
 rtl/fft_mem_sequencer.sv | 132 +++++++++++++
 tb/tb_fft_mem_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_mem_sequencer_if.sv
// Handshake and address bundle between the FFT memory sequencer and its surroundings
// (input stream, sample RAM write port, butterfly unit, output stream).
interface fft_mem_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOG2N  = 10,
  parameter int LW         = $clog2(MAX_LOG2N + 1)
) ();
  localparam int AW = MAX_LOG2N;

  logic                    start;
  logic [LW-1:0]           cfg_log2n;
  logic                    in_valid;
  logic                    in_ready;
  logic [2*DATA_WIDTH-1:0] in_data;
  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [2*DATA_WIDTH-1:0] mem_wdata;
  logic                    bf_valid;
  logic                    bf_ready;
  logic [AW-1:0]           bf_addr_a;
  logic [AW-1:0]           bf_addr_b;
  logic [AW-2:0]           bf_tw_idx;
  logic                    wb_valid;
  logic                    out_valid;
  logic                    out_ready;
  logic [AW-1:0]           out_addr;
  logic [LW-1:0]           cur_stage;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;

  modport master (
    input  start, cfg_log2n, in_valid, in_data, bf_ready, wb_valid, out_ready,
    output in_ready, mem_we, mem_waddr, mem_wdata, bf_valid, bf_addr_a, bf_addr_b,
           bf_tw_idx, out_valid, out_addr, cur_stage, busy, done, cfg_err
  );

  modport slave (
    output start, cfg_log2n, in_valid, in_data, bf_ready, wb_valid, out_ready,
    input  in_ready, mem_we, mem_waddr, mem_wdata, bf_valid, bf_addr_a, bf_addr_b,
           bf_tw_idx, out_valid, out_addr, cur_stage, busy, done, cfg_err
  );
endinterface

// File: rtl/fft_mem_sequencer.sv
// Address/handshake sequencer for an in-place radix-2 DIT FFT of runtime size 2^cfg_log2n:
// bit-reversed load, per-stage butterfly issue with write-back barrier, natural-order unload.
module fft_mem_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOG2N  = 10,
  parameter int LW         = $clog2(MAX_LOG2N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  fft_mem_sequencer_if.master bus
);
  localparam int AW  = MAX_LOG2N;
  localparam int TWW = AW - 1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, BARRIER, UNLOAD} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, wb_cnt;
  logic [LW-1:0] log2n, stage;
  logic          done_q, cfg_err_q;

  logic          cnt_clr, cnt_inc, stage_inc, take_cfg, err_pulse, done_pulse;
  logic          cfg_legal, in_acc, bf_acc, out_acc, wb_full;
  logic [AW-1:0] n_mask, half_mask, n_half;
  logic [AW-1:0] half, pos, addr_a, rev;

  // n_mask = N-1 and half_mask = N/2-1 without ever forming N, which overflows AW bits at max size.
  assign n_mask    = {AW{1'b1}} >> (LW'(MAX_LOG2N) - log2n);
  assign half_mask = n_mask >> 1;
  assign n_half    = half_mask + AW'(1);

  assign cfg_legal = (bus.cfg_log2n != '0) && (bus.cfg_log2n <= LW'(MAX_LOG2N));
  assign in_acc    = (state == LOAD)   && bus.in_valid;
  assign bf_acc    = (state == ISSUE)  && bus.bf_ready;
  assign out_acc   = (state == UNLOAD) && bus.out_ready;
  assign wb_full   = (wb_cnt == n_half);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx   = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    stage_inc  = 1'b0;
    take_cfg   = 1'b0;
    err_pulse  = 1'b0;
    done_pulse = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        if (cfg_legal) begin
          take_cfg = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = LOAD;
        end else begin
          err_pulse = 1'b1;
        end
      end
      LOAD: if (in_acc) begin
        if (cnt == n_mask) begin
          cnt_clr  = 1'b1;
          state_nx = ISSUE;
        end else cnt_inc = 1'b1;
      end
      ISSUE: if (bf_acc) begin
        if (cnt == half_mask) begin
          cnt_clr  = 1'b1;
          state_nx = BARRIER;
        end else cnt_inc = 1'b1;
      end
      BARRIER: if (wb_full) begin
        stage_inc = 1'b1;
        state_nx  = (stage + LW'(1) == log2n) ? UNLOAD : ISSUE;
      end
      UNLOAD: if (out_acc) begin
        if (cnt == n_mask) begin
          cnt_clr    = 1'b1;
          done_pulse = 1'b1;
          state_nx   = IDLE;
        end else cnt_inc = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wb_cnt    <= '0;
      log2n     <= '0;
      stage     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      done_q    <= done_pulse;
      cfg_err_q <= err_pulse;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + AW'(1);
      if (take_cfg)        log2n <= bus.cfg_log2n;
      if (take_cfg || done_pulse) stage <= '0;
      else if (stage_inc)         stage <= stage + LW'(1);
      // Clearing on stage advance drops any same-cycle pulse so nothing carries into the next stage.
      if (take_cfg || stage_inc) wb_cnt <= '0;
      else if ((state == ISSUE || state == BARRIER) && bus.wb_valid && !wb_full)
        wb_cnt <= wb_cnt + AW'(1);
    end
  end

  always_comb begin
    rev = '0;
    for (int i = 0; i < AW; i++) rev[i] = cnt[AW-1-i];
    half   = AW'(1) << stage;
    pos    = cnt & (half - AW'(1));
    addr_a = ((cnt >> stage) << (stage + LW'(1))) | pos;
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.mem_we    = in_acc;
  assign bus.mem_waddr = (state == LOAD) ? (rev >> (LW'(MAX_LOG2N) - log2n)) : '0;
  assign bus.mem_wdata = (state == LOAD) ? bus.in_data : {2*DATA_WIDTH{1'b0}};
  assign bus.bf_valid  = (state == ISSUE);
  assign bus.bf_addr_a = (state == ISSUE) ? addr_a : '0;
  assign bus.bf_addr_b = (state == ISSUE) ? (addr_a + half) : '0;
  assign bus.bf_tw_idx = (state == ISSUE) ? TWW'(pos << (LW'(MAX_LOG2N - 1) - stage)) : '0;
  assign bus.out_valid = (state == UNLOAD);
  assign bus.out_addr  = (state == UNLOAD) ? cnt : '0;
  assign bus.cur_stage = stage;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Directed bench for fft_mem_sequencer: hand tables for N=8, a small reference model for N=2/N=64,
// barrier hold, backpressure, illegal sizes and mid-run reset.
module tb_fft_mem_sequencer;
  localparam int DW   = 16;
  localparam int MAXL = 10;
  localparam int LW   = $clog2(MAXL + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_mem_sequencer_if #(.DATA_WIDTH(DW), .MAX_LOG2N(MAXL)) bus ();

  fft_mem_sequencer #(.DATA_WIDTH(DW), .MAX_LOG2N(MAXL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int exp_ld[256];
  int exp_a[256];
  int exp_b[256];
  int exp_tw[256];
  int exp_s[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bitrev(input int k, input int l);
    int r = 0;
    for (int i = 0; i < l; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  // Pairs enumerated group by group: group base g steps by 2*half, leg offset p inside the group.
  task automatic build_model(input int l);
    int n = 1 << l;
    int idx = 0;
    for (int k = 0; k < n; k++) exp_ld[k] = bitrev(k, l);
    for (int s = 0; s < l; s++) begin
      int half = 1 << s;
      for (int g = 0; g < n; g += 2 * half)
        for (int p = 0; p < half; p++) begin
          exp_a[idx]  = g + p;
          exp_b[idx]  = g + p + half;
          exp_tw[idx] = p << (MAXL - 1 - s);
          exp_s[idx]  = s;
          idx++;
        end
    end
  endtask

  task automatic load_n8_tables();
    int ld[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int tw[12] = '{0, 0, 0, 0, 0, 256, 0, 256, 0, 128, 256, 384};
    for (int k = 0; k < 8; k++) exp_ld[k] = ld[k];
    for (int i = 0; i < 12; i++) begin
      exp_a[i] = a[i]; exp_b[i] = b[i]; exp_tw[i] = tw[i]; exp_s[i] = i / 4;
    end
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.cfg_log2n = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.bf_ready = 1'b0; bus.wb_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   bus.busy, 0);
    check({tag, "_inrdy"},  bus.in_ready, 0);
    check({tag, "_we"},     bus.mem_we, 0);
    check({tag, "_waddr"},  bus.mem_waddr, 0);
    check({tag, "_bfv"},    bus.bf_valid, 0);
    check({tag, "_bfa"},    bus.bf_addr_a, 0);
    check({tag, "_bfb"},    bus.bf_addr_b, 0);
    check({tag, "_tw"},     bus.bf_tw_idx, 0);
    check({tag, "_outv"},   bus.out_valid, 0);
    check({tag, "_oaddr"},  bus.out_addr, 0);
    check({tag, "_stage"},  bus.cur_stage, 0);
    check({tag, "_done"},   bus.done, 0);
    check({tag, "_cfgerr"}, bus.cfg_err, 0);
  endtask

  // Full transform: wb_valid echoes each accepted pair 2 cycles later; start/cfg noise while busy.
  task automatic run_xform(input int l, input bit rand_bp, input string tag);
    int n = 1 << l;
    int npairs = l * (n / 2);
    int ld_k = 0, bf_k = 0, out_k = 0, dones = 0, cyc = 0;
    bit [1:0] pipe = 2'b00;
    bit bf_hold = 1'b0, out_hold = 1'b0;
    logic [31:0] ha = 0, hb = 0, ht = 0, ho = 0;
    logic [31:0] word;
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_log2n = LW'(l);
    @(negedge clk);
    while (dones == 0 && cyc < 4000) begin
      bus.start     = bus.busy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.cfg_log2n = LW'($urandom_range(0, 15));
      bus.in_valid  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.bf_ready  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wb_valid  = pipe[1];
      word          = $urandom;
      bus.in_data   = word;
      #1;
      if (bus.mem_we) begin
        if (ld_k < n) check({tag, "_waddr"}, bus.mem_waddr, exp_ld[ld_k]);
        check({tag, "_wdata"}, bus.mem_wdata, word);
        ld_k++;
      end
      if (bf_hold) begin
        check({tag, "_bf_hold_v"}, bus.bf_valid, 1);
        check({tag, "_bf_hold_a"}, bus.bf_addr_a, ha);
        check({tag, "_bf_hold_b"}, bus.bf_addr_b, hb);
        check({tag, "_bf_hold_t"}, bus.bf_tw_idx, ht);
      end
      bf_hold = 1'b0;
      if (bus.bf_valid && bus.bf_ready) begin
        if (bf_k < npairs) begin
          check({tag, "_bf_a"},  bus.bf_addr_a, exp_a[bf_k]);
          check({tag, "_bf_b"},  bus.bf_addr_b, exp_b[bf_k]);
          check({tag, "_bf_tw"}, bus.bf_tw_idx, exp_tw[bf_k]);
          check({tag, "_stage"}, bus.cur_stage, exp_s[bf_k]);
        end
        bf_k++;
      end else if (bus.bf_valid) begin
        bf_hold = 1'b1; ha = bus.bf_addr_a; hb = bus.bf_addr_b; ht = bus.bf_tw_idx;
      end
      if (out_hold) begin
        check({tag, "_out_hold_v"}, bus.out_valid, 1);
        check({tag, "_out_hold_a"}, bus.out_addr, ho);
      end
      out_hold = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        check({tag, "_out_addr"}, bus.out_addr, out_k);
        out_k++;
      end else if (bus.out_valid) begin
        out_hold = 1'b1; ho = bus.out_addr;
      end
      if (bus.done) dones++;
      pipe = {pipe[0], bus.bf_valid & bus.bf_ready};
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    check({tag, "_done_once"}, dones, 1);
    check({tag, "_loads"},  ld_k, n);
    check({tag, "_pairs"},  bf_k, npairs);
    check({tag, "_unload"}, out_k, n);
    #1;
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic cfg_err_case(input int l, input string tag);
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_log2n = LW'(l);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check({tag, "_pulse"}, bus.cfg_err, 1);
    check({tag, "_busy"},  bus.busy, 0);
    @(negedge clk); #1;
    check({tag, "_clear"}, bus.cfg_err, 0);
    check({tag, "_idle"},  bus.busy, 0);
  endtask

  initial begin
    int k;
    bit found;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk); #1;
    check_quiet("post_reset");

    cfg_err_case(0, "cfg0");
    cfg_err_case(11, "cfg11");

    load_n8_tables();
    run_xform(3, 1'b0, "n8");
    run_xform(3, 1'b1, "n8_bp");

    build_model(1);
    run_xform(1, 1'b1, "n2");

    // Barrier: stage 0 issued, write-backs withheld.
    load_n8_tables();
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_log2n = 3'd3; bus.in_valid = 1'b1; bus.bf_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      #1;
      if (bus.bf_valid) k++;
      @(negedge clk);
    end
    check("bar_issued", k, 4);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bar_bfv", bus.bf_valid, 0);
      check("bar_stage", bus.cur_stage, 0);
      check("bar_busy", bus.busy, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      bus.wb_valid = 1'b1;
      @(negedge clk);
      bus.wb_valid = 1'b0;
      #1;
      if (i < 3) begin
        check("bar_wait_bfv", bus.bf_valid, 0);
        check("bar_wait_stage", bus.cur_stage, 0);
      end
    end
    bus.bf_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      if (bus.bf_valid) found = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("bar_release", found, 1);
    check("bar_s1_stage", bus.cur_stage, 1);
    check("bar_s1_a", bus.bf_addr_a, 0);
    check("bar_s1_b", bus.bf_addr_b, 2);
    check("bar_s1_tw", bus.bf_tw_idx, 0);

    // Reset while a stage-1 pair is pending.
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    check_quiet("mid_rst");
    rst = 1'b0;

    build_model(6);
    run_xform(6, 1'b1, "n64");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
